sig_mmio_sink: RTL and testbench

- Synthesizable memory-mapped signature/halt device directly downstream of the pipeline's MEM stage.
- Snoops MEM-stage stores:
  - stores to SIG_ADDR are queued in a FIFO and drained over a valid/ready stream to the bench or a host link;
  - a store to HALT_ADDR drains the FIFO, then raises halt.
- Replaces bench-side hierarchical probing of the data memory write path.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/sig_fifo.sv | 34 +++
 rtl/sig_mmio_sink.sv | 81 ++++++++
 tb/tb_sig_mmio_sink.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and default addresses for the MEM-stage signature sink
package pipe_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} sink_state_e;
  localparam word_t SIG_ADDR_DEF = 32'hFF00_0000;
  localparam word_t HALT_ADDR_DEF = 32'hCAFE_BEEF;
endpackage

// File: rtl/sig_fifo.sv
// sig_fifo: DEPTH x 32 synchronous FIFO with extra-MSB pointers, async active-low reset
module sig_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  word_t                  din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output word_t                  head
);
  localparam int AW = $clog2(DEPTH);
  word_t mem [DEPTH];
  logic [AW:0] wr, rd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + (AW+1)'(1);
      if (pop) rd <= rd + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= din;
  assign empty = wr == rd;
  assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign level = wr - rd;
  assign head  = empty ? '0 : mem[rd[AW-1:0]];
endmodule

// File: rtl/sig_mmio_sink.sv
// sig_mmio_sink: snoops MEM-stage stores, streams signature words, halts after draining.
// Optional watchdog enabled by defining SIG_TIMEOUT_EN.
module sig_mmio_sink
  import pipe_pkg::*;
#(
  parameter word_t       SIG_ADDR       = SIG_ADDR_DEF,
  parameter word_t       HALT_ADDR      = HALT_ADDR_DEF,
  parameter int          DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_en,
  input  word_t       st_addr,
  input  word_t       st_data,
  output logic        stall,
  output logic        sig_valid,
  output word_t       sig_data,
  input  logic        sig_ready,
  output logic [15:0] sig_count,
  output logic        halt,
  output logic        timeout
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
    $error("sig_mmio_sink: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES nonzero");
  sink_state_e state, state_nx;
  logic full, empty, pop, push, sig_hit, halt_hit, empty_nx, expire;
  logic [AW:0] level;
  // SIG decode wins if the two addresses are ever configured equal
  assign sig_hit   = st_en && st_addr == SIG_ADDR;
  assign halt_hit  = st_en && st_addr == HALT_ADDR && !sig_hit;
  assign sig_valid = !empty;
  assign pop       = sig_valid && sig_ready;
  assign stall     = state == RUN && sig_hit && full && !pop;
  assign push      = state == RUN && sig_hit && !stall;
  assign empty_nx  = (empty || (pop && level == (AW+1)'(1))) && !push;
  sig_fifo #(.DEPTH(DEPTH)) fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (st_data),
    .full (full),
    .empty(empty),
    .level(level),
    .head (sig_data)
  );
`ifdef SIG_TIMEOUT_EN
  logic [31:0] cyc;
  logic        to;
  assign expire  = state == RUN && !halt_hit && cyc == TIMEOUT_CYCLES - 1;
  assign timeout = to;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cyc <= '0;
      to  <= 1'b0;
    end else begin
      if (state == RUN) cyc <= cyc + 32'd1;
      if (expire) to <= 1'b1;
    end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    if (state == RUN && (halt_hit || expire)) state_nx = empty_nx ? HALTED : DRAIN;
    if (state == DRAIN && empty_nx) state_nx = HALTED;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= RUN;
      halt      <= 1'b0;
      sig_count <= '0;
    end else begin
      state     <= state_nx;
      halt      <= state_nx == HALTED;
      sig_count <= (push && sig_count != 16'hFFFF) ? sig_count + 16'd1 : sig_count;
    end
endmodule

// File: tb/tb_sig_mmio_sink.sv
// tb_sig_mmio_sink: directed stores with a scoreboard queue checked by a stream monitor
module tb_sig_mmio_sink;
  import pipe_pkg::*;
  localparam word_t SA = 32'hFF00_0000;
  localparam word_t HA = 32'hCAFE_BEEF;
  logic clk = 1'b0, rst = 1'b0, st_en = 1'b0, sig_ready = 1'b0;
  word_t st_addr = '0, st_data = '0;
  logic stall, sig_valid, halt, timeout;
  word_t sig_data;
  logic [15:0] sig_count;
  int n_chk = 0, n_fail = 0;
  word_t exp_q[$];
  always #5 clk = ~clk;
  sig_mmio_sink #(.DEPTH(16), .TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_en    (st_en),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .stall    (stall),
    .sig_valid(sig_valid),
    .sig_data (sig_data),
    .sig_ready(sig_ready),
    .sig_count(sig_count),
    .halt     (halt),
    .timeout  (timeout)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Every handshake on the stream must match the oldest expected word
  always @(negedge clk)
    if (rst && sig_valid && sig_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", sig_data, 32'hxxxx_xxxx);
      else chk("stream_word", sig_data, exp_q.pop_front());
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    st_en = 1'b0;
    sig_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask
  task automatic store(word_t a, word_t d, bit cap);
    st_en = 1'b1;
    st_addr = a;
    st_data = d;
    if (cap) exp_q.push_back(d);
    tick();
    st_en = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_sig_mmio_sink watchdog");
  end
  initial begin
    do_reset();
    chk("rst_valid", 32'(sig_valid), 0);
    chk("rst_data", sig_data, 0);
    chk("rst_count", 32'(sig_count), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_timeout", 32'(timeout), 0);
    sig_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      store(SA, word_t'(32'h11 * i), 1'b1);
      chk("t1_valid_after_push", 32'(sig_valid), 1);
      tick();
      chk("t1_drained", 32'(sig_valid), 0);
    end
    chk("t1_count", 32'(sig_count), 3);
    chk("t1_halt", 32'(halt), 0);
    sig_ready = 1'b0;
    for (int i = 0; i < 16; i++) store(SA, word_t'(32'h200 + i), 1'b1);
    chk("t2_count16", 32'(sig_count), 19);
    st_en = 1'b1;
    st_addr = SA;
    st_data = 32'h210;
    exp_q.push_back(32'h210);
    #1;
    chk("t2_stall_full", 32'(stall), 1);
    tick();
    chk("t2_stall_held", 32'(stall), 1);
    chk("t2_count_held", 32'(sig_count), 19);
    sig_ready = 1'b1;
    #1;
    chk("t2_stall_drop", 32'(stall), 0);
    tick();
    st_en = 1'b0;
    chk("t2_count17", 32'(sig_count), 20);
    repeat (20) tick();
    chk("t2_empty", 32'(sig_valid), 0);
    chk("t2_queue", 32'(exp_q.size()), 0);
    sig_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(SA, word_t'(32'h300 + i), 1'b1);
    store(HA, 32'h0, 1'b0);
    chk("t3_halt_drain", 32'(halt), 0);
    chk("t3_valid_drain", 32'(sig_valid), 1);
    st_en = 1'b1;
    st_addr = SA;
    st_data = 32'hDEAD;
    #1;
    chk("t3_no_stall_drain", 32'(stall), 0);
    tick();
    st_en = 1'b0;
    chk("t3_count_drain", 32'(sig_count), 24);
    sig_ready = 1'b1;
    repeat (3) tick();
    chk("t3_halt_before_last", 32'(halt), 0);
    tick();
    chk("t3_halt_after_last", 32'(halt), 1);
    chk("t3_empty", 32'(sig_valid), 0);
    store(SA, 32'h55, 1'b0);
    chk("t3_count_halted", 32'(sig_count), 24);
    chk("t3_halt_sticky", 32'(halt), 1);
    do_reset();
    chk("t4_halt_rst", 32'(halt), 0);
    store(HA, 32'h0, 1'b0);
    chk("t4_halt_empty", 32'(halt), 1);
    do_reset();
    sig_ready = 1'b1;
    store(SA + 32'd4, 32'h66, 1'b0);
    st_en = 1'b0;
    st_addr = SA;
    st_data = 32'h77;
    tick();
    chk("t5_count", 32'(sig_count), 0);
    chk("t5_valid", 32'(sig_valid), 0);
    store(SA, 32'h88, 1'b1);
    chk("t5_count_real", 32'(sig_count), 1);
    tick();
`ifndef SIG_TIMEOUT_EN
    chk("t5_timeout_tied", 32'(timeout), 0);
`endif
    sig_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(SA, word_t'(32'h600 + i), 1'b1);
    store(HA, 32'h0, 1'b0);
    chk("t6_valid_drain", 32'(sig_valid), 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_async_valid", 32'(sig_valid), 0);
    chk("t6_async_halt", 32'(halt), 0);
    chk("t6_async_count", 32'(sig_count), 0);
    chk("t6_async_stall", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    sig_ready = 1'b1;
    store(SA, 32'h99, 1'b1);
    chk("t6_run_again", 32'(sig_count), 1);
    tick();
`ifdef SIG_TIMEOUT_EN
    do_reset();
    repeat (98) tick();
    chk("t6_timeout_early", 32'(timeout), 0);
    chk("t6_halt_early", 32'(halt), 0);
    tick();
    chk("t6_timeout", 32'(timeout), 1);
    chk("t6_timeout_halt", 32'(halt), 1);
`endif
    chk("final_queue", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
